// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte-stream requesters.
// Define UART_TX_ARB_LOCK_EN to keep the grant on one requester until it sends a word with req_last set.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 9,
  parameter int TIMEOUT = 2_000_000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         uart_start,
  output logic [DATA_W-1:0]            uart_data,
  input  logic                         uart_ready,
  input  logic                         uart_busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         active,
  output logic                         timeout_err
);

  localparam int ID_W = $clog2(NUM_REQ);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t            state_reg;
  logic [ID_W-1:0]   ptr_reg;
  logic [WD_W-1:0]   wd_reg;
  logic [DATA_W-1:0] words [NUM_REQ];
  logic [NUM_REQ-1:0] eligible;
  logic [ID_W-1:0]   winner;
  logic              found;
  logic              accept;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_words
    assign words[gi] = req_data[gi*DATA_W +: DATA_W];
  end

`ifdef UART_TX_ARB_LOCK_EN
  logic            lock_reg;
  logic [ID_W-1:0] lock_id_reg;

  always_comb begin
    eligible = req_valid;
    if (lock_reg)
      eligible = req_valid & (NUM_REQ'(1) << lock_id_reg);
  end
`else
  logic unused_last;
  assign unused_last = ^req_last;
  assign eligible    = req_valid;
`endif

  // Search starts just after the last winner, so every requester gets a turn.
  always_comb begin
    winner = ptr_reg;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && eligible[ID_W'((int'(ptr_reg) + k) % NUM_REQ)]) begin
        found  = 1'b1;
        winner = ID_W'((int'(ptr_reg) + k) % NUM_REQ);
      end
    end
  end

  assign accept    = !rst && (state_reg == IDLE) && uart_ready && !uart_busy && found;
  assign req_ready = accept ? (NUM_REQ'(1) << winner) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      ptr_reg     <= ID_W'(NUM_REQ - 1);
      wd_reg      <= '0;
      uart_start  <= 1'b0;
      uart_data   <= '0;
      grant_id    <= '0;
      active      <= 1'b0;
      timeout_err <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
      lock_reg    <= 1'b0;
      lock_id_reg <= '0;
`endif
    end else begin
      uart_start  <= 1'b0;
      timeout_err <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            uart_data  <= words[winner];
            grant_id   <= winner;
            ptr_reg    <= winner;
            uart_start <= 1'b1;
            active     <= 1'b1;
            state_reg  <= ISSUE;
`ifdef UART_TX_ARB_LOCK_EN
            lock_reg    <= !req_last[winner];
            lock_id_reg <= winner;
`endif
          end
        end
        ISSUE: begin
          wd_reg    <= '0;
          state_reg <= WAIT_BUSY;
        end
        default: begin
          if (state_reg == WAIT_DONE && !uart_busy && uart_ready) begin
            state_reg <= IDLE;
            active    <= 1'b0;
          end else if (wd_reg == WD_W'(TIMEOUT - 2)) begin
            // Fires here so timeout_err lands exactly TIMEOUT cycles after uart_start.
            state_reg   <= IDLE;
            active      <= 1'b0;
            timeout_err <= 1'b1;
`ifdef UART_TX_ARB_LOCK_EN
            lock_reg    <= 1'b0;
`endif
          end else begin
            if (state_reg == WAIT_BUSY && uart_busy)
              state_reg <= WAIT_DONE;
            if (wd_reg != {WD_W{1'b1}})
              wd_reg <= wd_reg + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: transaction-level model plus directed scenarios.
// Build with UART_TX_ARB_LOCK_EN defined to exercise the packet-lock variant.
module tb_uart_tx_arbiter;

  localparam int N     = 4;
  localparam int W     = 9;
  localparam int TO    = 16;
  localparam int FRAME = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic           uart_start;
  logic [W-1:0]   uart_data;
  logic           uart_ready = 1'b1;
  logic           uart_busy = 1'b0;
  logic [1:0]     grant_id;
  logic           active;
  logic           timeout_err;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .uart_start(uart_start), .uart_data(uart_data),
    .uart_ready(uart_ready), .uart_busy(uart_busy), .grant_id(grant_id),
    .active(active), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc_n = 0;
  logic rst_cmd = 1'b1;
  int mode = 0;          // 0 normal driver, 1 never busy, 2 not ready, 3 ready but busy
  int u_cnt = 0;
  logic [N-1:0] acc_s = '0;
  logic start_s = 1'b0;
  logic [9:0] wq [0:N-1][$];   // bit 9 = last flag
  int dut_log[$], model_log[$], acc_log[$], start_log[$], terr_log[$];

  // transaction-level model state
  logic chk_en = 1'b0;
  logic m_xfer = 1'b0, m_saw = 1'b0, m_terr = 1'b0, m_lock = 1'b0;
  int   m_age = 0, m_ptr = N - 1, m_grant = 0, m_lock_id = 0;
  logic [W-1:0] m_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  always @(posedge clk) cyc_n++;

  // requesters and UART driver model, applied just after each edge
  always @(posedge clk) begin
    logic [9:0] f;
    #1;
    rst = rst_cmd;
    for (int i = 0; i < N; i++) begin
      if (acc_s[i] && wq[i].size() > 0) void'(wq[i].pop_front());
      req_valid[i] = wq[i].size() > 0;
      f = (wq[i].size() > 0) ? wq[i][0] : 10'h0;
      req_data[i*W +: W] = f[8:0];
      req_last[i] = f[9];
    end
    if (rst_cmd || mode != 0) u_cnt = 0;
    else if (start_s) u_cnt = FRAME;
    else if (u_cnt > 0) u_cnt--;
    case (mode)
      1: begin uart_busy = 1'b0; uart_ready = 1'b1; end
      2: begin uart_busy = 1'b0; uart_ready = 1'b0; end
      3: begin uart_busy = 1'b1; uart_ready = 1'b1; end
      default: begin uart_busy = (u_cnt > 0); uart_ready = (u_cnt == 0); end
    endcase
  end

  // model evaluation, comparison and logging, away from the active edge
  always @(negedge clk) begin : mon
    logic [N-1:0] elig, e_ready;
    logic found, done;
    int w, idx;
    elig = req_valid;
`ifdef UART_TX_ARB_LOCK_EN
    if (m_lock) elig = req_valid & (4'b1 << m_lock_id);
`endif
    found = 1'b0;
    w = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (m_ptr + k) % N;
      if (!found && elig[idx]) begin found = 1'b1; w = idx; end
    end
    e_ready = (!rst && !m_xfer && uart_ready && !uart_busy && found) ? (4'b1 << w) : 4'b0;
    if (chk_en) begin
      check("req_ready", req_ready, e_ready);
      check("uart_start", uart_start, m_xfer && m_age == 1);
      check("uart_data", uart_data, m_data);
      check("grant_id", grant_id, m_grant);
      check("active", active, m_xfer);
      check("timeout_err", timeout_err, m_terr);
    end
    if (req_ready != 0) begin
      for (int i = 0; i < N; i++) if (req_ready[i]) dut_log.push_back(i);
      acc_log.push_back(cyc_n);
      $display("accept req_ready=%b data=%03h cycle=%0d", req_ready, req_data, cyc_n);
    end
    if (uart_start) start_log.push_back(cyc_n);
    if (timeout_err) terr_log.push_back(cyc_n);
    acc_s = req_ready;
    start_s = uart_start;
    // advance the model to the next cycle
    if (rst) begin
      m_xfer = 0; m_age = 0; m_saw = 0; m_ptr = N - 1; m_grant = 0;
      m_data = '0; m_terr = 0; m_lock = 0; chk_en = 1'b1;
    end else begin
      m_terr = 0;
      if (!m_xfer) begin
        if (e_ready != 0) begin
          m_xfer = 1; m_age = 1; m_saw = 0;
          m_ptr = w; m_grant = w; m_data = req_data[w*W +: W];
          m_lock = !req_last[w]; m_lock_id = w;
          model_log.push_back(w);
        end
      end else begin
        done = 1'b0;
        if (m_age >= 2) begin
          if (!m_saw) m_saw = uart_busy;
          else done = !uart_busy && uart_ready;
        end
        if (done) m_xfer = 0;
        else if (m_age == TO) begin m_xfer = 0; m_terr = 1; m_lock = 0; end
        else m_age++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic clear_logs();
    dut_log.delete(); model_log.delete(); acc_log.delete(); start_log.delete(); terr_log.delete();
  endtask

  task automatic do_reset();
    rst_cmd = 1'b1;
    cyc(2);
    rst_cmd = 1'b0;
    cyc(1);
    clear_logs();
  endtask

  task automatic wait_grants(input int n);
    int b = 0;
    while (dut_log.size() < n && b < 400) begin @(negedge clk); b++; end
    check("wait_grants", (dut_log.size() >= n) ? n : dut_log.size(), n);
  endtask

  task automatic wait_idle();
    int b = 0;
    logic empty;
    do begin
      @(negedge clk);
      b++;
      empty = 1'b1;
      for (int i = 0; i < N; i++) if (wq[i].size() != 0) empty = 1'b0;
    end while (!(empty && !active && !uart_busy) && b < 600);
    check("wait_idle", b < 600, 1);
  endtask

  initial begin
    int exp_rr [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
`ifdef UART_TX_ARB_LOCK_EN
    int exp_lk [5] = '{2, 2, 2, 0, 0};
`else
    int exp_lk [5] = '{2, 0, 2, 0, 2};
`endif
    cyc(3);
    rst_cmd = 1'b0;
    cyc(1);
    @(negedge clk);
    check("rst_outputs", {req_ready, uart_start, uart_data, grant_id, active, timeout_err}, 0);

    // reset in the middle of a transfer
    clear_logs();
    wq[3].push_back(10'h355);
    wait_grants(1);
    while (!uart_busy && cyc_n < 200) @(negedge clk);
    cyc(2);
    rst_cmd = 1'b1;
    cyc(1);
    rst_cmd = 1'b0;
    @(negedge clk);
    check("midrst_outputs", {req_ready, uart_start, uart_data, grant_id, active, timeout_err}, 0);
    clear_logs();
    wq[0].push_back(10'h201);
    wq[2].push_back(10'h202);
    @(negedge clk);
    check("midrst_first_ready", req_ready, 4'b0001);
    wait_grants(2);
    wait_idle();
    check("midrst_order0", dut_log[0], 0);
    check("midrst_order1", dut_log[1], 2);

    // single word, then a second word from the same requester
    do_reset();
    wq[1].push_back(10'h2A5);
    @(negedge clk);
    check("single_ready", req_ready, 4'b0010);
    @(negedge clk);
    check("single_start", uart_start, 1);
    check("single_data", uart_data, 9'h0A5);
    wq[1].push_back(10'h23C);
    @(negedge clk);
    check("single_start_gone", uart_start, 0);
    wait_grants(2);
    wait_idle();
    check("single_spacing", acc_log[1] - acc_log[0], 3 + FRAME);
    check("single_start_cnt", start_log.size(), 2);

    // round robin with all requesters busy
    do_reset();
    for (int i = 0; i < N; i++) begin
      wq[i].push_back(10'h200 | 10'(i));
      wq[i].push_back(10'h210 | 10'(i));
    end
    wait_grants(8);
    wait_idle();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rr_dut_%0d", i), dut_log[i], exp_rr[i]);
      check($sformatf("rr_model_%0d", i), model_log[i], exp_rr[i]);
    end

    // watchdog: driver never goes busy (pointer is at 3 after round robin)
    clear_logs();
    mode = 1;
    wq[1].push_back(10'h211);
    wq[2].push_back(10'h222);
    begin
      int b = 0;
      while (terr_log.size() < 2 && b < 200) begin @(negedge clk); b++; end
    end
    check("wd_terr_cnt", terr_log.size(), 2);
    check("wd_grant0", dut_log[0], 1);
    check("wd_grant1", dut_log[1], 2);
    check("wd_delay0", terr_log[0] - start_log[0], TO);
    check("wd_delay1", terr_log[1] - start_log[1], TO);
    check("wd_regrant", acc_log[1], terr_log[0]);
    mode = 0;
    wait_idle();

    // packet lock stimulus
    do_reset();
    wq[2].push_back(10'h1A0);
    wq[2].push_back(10'h1A1);
    wq[2].push_back(10'h3A2);
    wait_grants(1);
    wq[0].push_back(10'h2B0);
    wq[0].push_back(10'h2B1);
    wait_grants(5);
    wait_idle();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("lock_dut_%0d", i), dut_log[i], exp_lk[i]);
      check($sformatf("lock_model_%0d", i), model_log[i], exp_lk[i]);
    end

    // busy gating
    do_reset();
    mode = 2;
    wq[3].push_back(10'h2F3);
    repeat (5) begin
      @(negedge clk);
      check("gate_not_ready", req_ready, 0);
    end
    mode = 3;
    repeat (3) begin
      @(negedge clk);
      check("gate_busy", req_ready, 0);
    end
    mode = 0;
    @(negedge clk);
    check("gate_release", req_ready, 4'b1000);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc_n);
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one `UART_driver` transmitter among `NUM_REQ` byte-stream requesters. Each requester has a valid/ready handshake. The block accepts one word at a time under round-robin arbitration and sequences the driver's `UART_Start`/`data_in` against `UART_Ready`/`UART_Busy`. A watchdog aborts a transfer the driver never completes. It sits between the system-side producers (debug console, status reporter, etc.) and the `UART_driver` instance.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 9: word width, matching the driver `data_in`.
- `TIMEOUT`, 2_000_000: clk cycles allowed per word from `uart_start` to completion.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NUM_REQ  requester i has a word pending.
- `req_data`  in  NUM_REQ*DATA_W  word of requester i at bits [i*DATA_W +: DATA_W].
- `req_last`  in  NUM_REQ  word is the last of a packet; used only with the lock feature.
- `req_ready`  out  NUM_REQ  one-hot accept strobe, combinational.
- `uart_start`  out  1  to driver `UART_Start`; one-cycle pulse.
- `uart_data`  out  DATA_W  to driver `data_in`; registered, held until the next accept.
- `uart_ready`  in  1  from driver `UART_Ready`.
- `uart_busy`  in  1  from driver `UART_Busy`.
- `grant_id`  out  $clog2(NUM_REQ)  index of the last accepted requester.
- `active`  out  1  high in any state except IDLE.
- `timeout_err`  out  1  one-cycle pulse on watchdog expiry.

## Operation
FSM states are IDLE, ISSUE, WAIT_BUSY and WAIT_DONE.
- **IDLE:**
  - Eligibility: `uart_ready`=1 and `uart_busy`=0 and at least one eligible `req_valid`.
  - Winner: the first valid index searching upward from `ptr+1` modulo `NUM_REQ`.
  - Accept: `req_ready[winner]`=1 in the same cycle. At the edge, capture `uart_data`, `grant_id`=winner and `ptr`=winner, then go to ISSUE.
- **ISSUE:** `uart_start`=1 for exactly one cycle, the watchdog clears, then go to WAIT_BUSY.
- **WAIT_BUSY:** wait for `uart_busy`=1, then go to WAIT_DONE.
- **WAIT_DONE:** wait for `uart_busy`=0 and `uart_ready`=1, then go to IDLE.
- **Watchdog:**
  - Counts every cycle in WAIT_BUSY and WAIT_DONE.
  - Width is $clog2(TIMEOUT+1) and it saturates; it never wraps.
  - On reaching `TIMEOUT`: pulse `timeout_err` for one cycle, go to IDLE, release any lock. `ptr` stays at the failed requester, so the next search starts after it.
- **Requester protocol:** a requester must hold `req_valid` and `req_data` stable until `req_ready`. `req_ready` is never asserted outside IDLE.
- **Simultaneous requests:** exactly one is granted. Losers wait; they are not dropped.
- **Reset mid-transfer:** FSM goes to IDLE and `ptr`=NUM_REQ-1, so requester 0 has first priority. No `uart_start` is issued in the cycle after reset.

## Timing
- **Reset values:**
  - Outputs: `req_ready`=0, `uart_start`=0, `uart_data`=0, `grant_id`=0, `active`=0, `timeout_err`=0.
  - Internal: lock cleared, watchdog 0.
- **Accept to start:** handshake at edge N; `uart_start` is high during cycle N+1 only; `uart_data` is valid from N+1.
- **Back-to-back:** minimum of 3 cycles plus the driver frame time between consecutive accepts.
- **Pass-through:** a requester asserting `req_valid` in IDLE with the UART idle is accepted in that same cycle. There is no added latency.
- **`active`:** registered, high from the cycle after accept until the cycle after the return to IDLE.

## Configuration
- `UART_TX_ARB_LOCK_EN` defined:
  - An accept with `req_last`=0 locks arbitration to that requester.
  - While locked, only that requester is eligible in IDLE.
  - An accepted word with `req_last`=1, or a timeout, clears the lock.
  - Locked `ptr` updates are identical (ptr = granted index).
- Undefined: `req_last` is ignored and every word is arbitrated independently.

## Test plan
- **Reset:** assert `rst` mid-WAIT_DONE -> next cycle all outputs are 0 and the FSM is in IDLE. Requesters 0 and 2 valid with the UART idle -> requester 0 is granted first.
- **Single word:** req 1 sends 9'h0A5 with the UART idle -> `req_ready`=4'b0010 in the same cycle. `uart_start` pulses once the next cycle with `uart_data`=9'h0A5. The next accept happens only after the model drops `uart_busy` and raises `uart_ready`.
- **Round-robin:** all 4 requesters continuously valid for 8 words -> grant order 0,1,2,3,0,1,2,3, with no starvation.
- **Watchdog:** `TIMEOUT`=16 and the driver model never raises `uart_busy` -> `timeout_err` pulses exactly 16 cycles after `uart_start`, FSM returns to IDLE, and the next grant goes to the following requester.
- **Lock (macro defined):** req 2 sends 3 words with `req_last`=0,0,1 while req 0 stays valid -> grants are 2,2,2,0. With the macro undefined the same stimulus gives grants 2,0,2,0,2.
- **Busy gating:** `req_valid` high while `uart_ready`=0 -> `req_ready` stays 0 until `uart_ready`=1 and `uart_busy`=0.
